// File: rtl/alu_response_collector_pkg.sv
// Shared types and constants for the ALU response collector.
package alu_response_collector_pkg;
   localparam int DATA_W  = 8;
   localparam int SEL_W   = 4;
   localparam int DEPTH   = 1 << SEL_W;
   localparam int ENTRY_W = DATA_W + 1;

   localparam logic [15:0] MISR_POLY = 16'h1021;
   localparam logic [15:0] MISR_SEED = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_DONE,
      ST_READOUT
   } state_t;
endpackage

// File: rtl/alu_response_collector_misr.sv
// 16-bit MISR folding one 9-bit {carry, result} word per enabled cycle.
module misr16
   import alu_response_collector_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        enable,
   input  logic [8:0]  data,
   output logic [15:0] value
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= MISR_SEED;
      end else if (clear) begin
         value <= MISR_SEED;
      end else if (enable) begin
         value <= {value[14:0], 1'b0} ^ (value[15] ? MISR_POLY : 16'h0000) ^ {7'b0, data};
      end
   end

endmodule

// File: rtl/alu_response_collector.sv
// Captures one ALU response per opcode into a buffer and a MISR, then
// streams the buffered responses out in opcode order over valid/ready.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for start; signature and results held
// ST_CAPTURE | storing responses, counting toward 16 captures
// ST_DONE    | sweep complete, entry 0 presented, moves on next cycle
// ST_READOUT | streaming entries until entry 15 is accepted
module alu_response_collector
   import alu_response_collector_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [SEL_W-1:0]  alu_sel,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              carryout,
   output logic              busy,
   output logic              done,
   output logic              err_order,
   output logic [15:0]       signature,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [SEL_W-1:0]  rd_sel,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_carry
);

   state_t             state;
   logic [SEL_W-1:0]   cnt;
   logic [SEL_W-1:0]   rd_ptr;
   logic [ENTRY_W-1:0] result_buf [DEPTH];
   logic [ENTRY_W-1:0] rd_entry;
   logic               capture_fire;
   logic               rd_xfer;

   // start wins over a capture arriving in the same cycle
   assign capture_fire = (state == ST_CAPTURE) && in_valid && !start;
   assign rd_xfer      = rd_valid && rd_ready;

   misr16 u_misr (
      .clk    (clk),
      .rst    (rst),
      .clear  (start),
      .enable (capture_fire),
      .data   ({carryout, alu_out}),
      .value  (signature)
   );

   always_ff @(posedge clk) begin
      if (capture_fire) begin
         result_buf[alu_sel] <= {carryout, alu_out};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         err_order <= 1'b0;
         rd_valid  <= 1'b0;
         cnt       <= '0;
         rd_ptr    <= '0;
      end else if (start) begin
         state     <= ST_CAPTURE;
         busy      <= 1'b1;
         done      <= 1'b0;
         err_order <= 1'b0;
         rd_valid  <= 1'b0;
         cnt       <= '0;
         rd_ptr    <= '0;
      end else begin
         case (state)
            ST_CAPTURE: begin
               if (in_valid) begin
                  cnt <= cnt + 1'b1;
                  if (alu_sel != cnt) begin
                     err_order <= 1'b1;
                  end
                  if (cnt == '1) begin
                     state    <= ST_DONE;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     rd_valid <= 1'b1;
                     rd_ptr   <= '0;
                  end
               end
            end
            ST_DONE, ST_READOUT: begin
               if (state == ST_DONE) begin
                  state <= ST_READOUT;
               end
               if (rd_xfer) begin
                  rd_ptr <= rd_ptr + 1'b1;
                  if (rd_ptr == '1) begin
                     state    <= ST_IDLE;
                     done     <= 1'b0;
                     rd_valid <= 1'b0;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // gated so the unwritten buffer never leaks out while idle
   assign rd_entry = result_buf[rd_ptr];
   assign rd_sel   = rd_ptr;
   assign rd_data  = rd_valid ? rd_entry[DATA_W-1:0] : '0;
   assign rd_carry = rd_valid ? rd_entry[DATA_W] : 1'b0;

endmodule

// File: doc/alu_response_collector.md
# alu_response_collector

Captures the response side of an ALU opcode sweep: it samples `{carryout, alu_out}` for each of the 16 `alu_sel` codes, stores them in a 16-entry result buffer, and folds them into a 16-bit MISR signature. A valid/ready port then streams the stored results out in opcode order. It sits on the output side of the ALU, opposite the stimulus sweep that drives `a`, `b` and `alu_sel`, and turns the ALU's per-opcode responses into a checkable record.

## Interface
- `DATA_W`, 8, ALU result width.
- `SEL_W`, 4, opcode width. Buffer depth is 2**SEL_W = 16.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a capture sweep.
- `in_valid`  in  1  the ALU response on this cycle is valid.
- `alu_sel`  in  SEL_W  opcode that produced the response.
- `alu_out`  in  DATA_W  ALU result.
- `carryout`  in  1  ALU carry flag.
- `busy`  out  1  high in CAPTURE.
- `done`  out  1  high in DONE and READOUT.
- `err_order`  out  1  sticky flag: a capture arrived out of sequence.
- `signature`  out  16  running MISR value; always visible.
- `rd_valid`  out  1  readout entry available.
- `rd_ready`  in  1  consumer accepts the readout entry.
- `rd_sel`  out  SEL_W  opcode index of the current readout entry.
- `rd_data`  out  DATA_W  stored `alu_out` for `rd_sel`.
- `rd_carry`  out  1  stored `carryout` for `rd_sel`.

## Operation
- States: IDLE, CAPTURE, DONE, READOUT.
- Reset values:
  - state IDLE.
  - `busy`, `done`, `err_order`, `rd_valid` = 0.
  - `signature` = 16'hFFFF.
  - `rd_sel` = 0, `rd_data` = 0, `rd_carry` = 0.
  - capture counter 0, read pointer 0.
  - Buffer contents are don't-care.
- `start`, in any state:
  - go to CAPTURE;
  - clear counter and read pointer;
  - set `signature` to 16'hFFFF and clear `err_order`.
  - `start` has priority over every other event in the same cycle.
- CAPTURE:
  - On each cycle with `in_valid`, write `{carryout, alu_out}` at index `alu_sel` and increment the counter.
  - If `alu_sel` differs from the counter, set `err_order`; the entry is still stored at `alu_sel`.
  - MISR update: shift `signature` left by 1; XOR with 16'h1021 if the old bit 15 was 1; then XOR with `{7'b0, carryout, alu_out}`.
  - After the 16th capture (counter wraps 15 -> 0), go to DONE.
- `in_valid` is ignored outside CAPTURE.
- DONE: `rd_valid` = 1 with read pointer 0; go to READOUT on the same cycle.
- READOUT:
  - A transfer occurs on a cycle where `rd_valid` and `rd_ready` are both high.
  - On each transfer the read pointer advances.
  - The transfer with pointer 15 returns the block to IDLE: `rd_valid` = 0, `done` = 0.
  - `signature` holds its value through DONE, READOUT and IDLE until the next `start`.
- While `rd_valid` is high and `rd_ready` is low, `rd_sel`, `rd_data` and `rd_carry` hold stable.
- Reset asserted mid-sweep or mid-readout aborts to the reset values immediately; there is no partial resume.

## Timing
- Capture: `in_valid` sampled at edge N; the buffer entry, counter and `signature` update at edge N, visible after edge N.
- DONE is entered at the edge of the 16th capture; `done` and `rd_valid` are high from the following cycle.
- Readout: `rd_data` and `rd_carry` are read combinationally from the buffer at the read pointer, giving zero-latency presentation.
  - Throughput is one entry per cycle when `rd_ready` is held high.
  - 16 transfers take exactly 16 cycles.
- Back-to-back captures on consecutive cycles are supported; `in_valid` gaps are allowed.

## Structure
- The shared package holds:
  - `DATA_W`, `SEL_W`;
  - the state enum (IDLE, CAPTURE, DONE, READOUT);
  - the MISR polynomial constant 16'h1021 and seed 16'hFFFF.
- One sub-module: `misr16`, with inputs clk, rst, clear, enable, 9-bit data and a 16-bit value output.
- The FSM, counter, buffer and readout logic stay in the top.

## Test plan
- Reset mid-CAPTURE after 5 captures -> all outputs return to reset values; `signature` = 16'hFFFF.
- `start`, then one capture with sel=0, out=8'h00, carry=0 -> `signature` = 16'hEFDF. A second capture with sel=1, out=8'h0C, carry=0 -> `signature` = 16'hCF93.
- Full sweep with sel=0..15, out = sel*3, carry = sel[0] -> `done` = 1 one cycle after the 16th capture and `err_order` = 0. Readout with `rd_ready` high yields `rd_sel` 0..15, `rd_data` 0,3,...,45 and `rd_carry` alternating 0,1 over 16 cycles, then IDLE.
- Sweep with sel 0,2,1,3..15 -> `err_order` = 1; entries are still stored by sel, and readout returns the correct per-opcode data.
- Readout with `rd_ready` toggled 1,0,0,1 -> entry held stable while `rd_ready` = 0; no entry is skipped or duplicated.
- `start` asserted during READOUT at pointer 7 -> immediate CAPTURE; `rd_valid` = 0, `signature` = 16'hFFFF, `err_order` cleared.
